// File: rtl/vx_fpu_lane_splitter.sv
// FPU lane splitter: breaks a NUM_THREADS warp request into NUM_LANES
// packets (pid ascending, sop/eop framed); FPU_SPLIT_SKIP_EN skips empty ones.
// Ports: in_* valid/ready request side, out_* valid/ready packet side.
module vx_fpu_lane_splitter #(
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 4,
  parameter int LANE_DATAW  = 96,
  parameter int META_W      = 64,
  localparam int NUM_PKTS   = NUM_THREADS / NUM_LANES,
  localparam int PID_W      =
    (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_THREADS-1:0]          in_tmask,
  input  logic [NUM_THREADS*LANE_DATAW-1:0] in_data,
  input  logic [META_W-1:0]               in_meta,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES-1:0]            out_tmask,
  output logic [NUM_LANES*LANE_DATAW-1:0] out_data,
  output logic [META_W-1:0]               out_meta,
  output logic [PID_W-1:0]                out_pid,
  output logic                            out_sop,
  output logic                            out_eop
);

  localparam int PKT_DW = NUM_LANES * LANE_DATAW;

  logic                            busy_q, busy_d;
  logic                            sop_q, sop_d;
  logic [PID_W-1:0]                pid_q, pid_d;
  logic [NUM_THREADS-1:0]          tmask_q, tmask_d;
  logic [NUM_THREADS*LANE_DATAW-1:0] data_q, data_d;
  logic [META_W-1:0]               meta_q, meta_d;

  logic [NUM_PKTS-1:0] pv_cur, pv_in;
  logic [PID_W-1:0]    first_pid, nxt_pid;
  logic                more;
  logic                in_fire, out_fire;

  // Partition-valid bits; with skipping off every partition counts.
  always_comb begin
    pv_cur = '1;
    pv_in  = '1;
`ifdef FPU_SPLIT_SKIP_EN
    for (int p = 0; p < NUM_PKTS; p++) begin
      pv_cur[p] = |tmask_q[p*NUM_LANES +: NUM_LANES];
      pv_in[p]  = |in_tmask[p*NUM_LANES +: NUM_LANES];
    end
`endif
  end

  // Priority encoders: lowest valid partition overall, and lowest
  // valid partition above the current pid. Empty mask falls to pid 0.
  always_comb begin
    first_pid = '0;
    nxt_pid   = '0;
    more      = 1'b0;
    for (int p = NUM_PKTS - 1; p >= 0; p--) begin
      if (pv_in[p]) begin
        first_pid = PID_W'(p);
      end
      if (pv_cur[p] && (p > int'(pid_q))) begin
        nxt_pid = PID_W'(p);
        more    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= 1'b0;
      sop_q   <= 1'b0;
      pid_q   <= '0;
      tmask_q <= '0;
      data_q  <= '0;
      meta_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      sop_q   <= sop_d;
      pid_q   <= pid_d;
      tmask_q <= tmask_d;
      data_q  <= data_d;
      meta_q  <= meta_d;
    end
  end

  assign out_fire = busy_q & out_ready;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    busy_d  = busy_q;
    sop_d   = sop_q;
    pid_d   = pid_q;
    tmask_d = tmask_q;
    data_d  = data_q;
    meta_d  = meta_q;
    if (out_fire) begin
      if (!more) begin
        busy_d = 1'b0;
      end else begin
        pid_d = nxt_pid;
        sop_d = 1'b0;
      end
    end
    // Capture wins over the eop retire so back-to-back has no bubble.
    if (in_fire) begin
      busy_d  = 1'b1;
      sop_d   = 1'b1;
      pid_d   = first_pid;
      tmask_d = in_tmask;
      data_d  = in_data;
      meta_d  = in_meta;
    end
  end

  always_comb begin
    out_valid = busy_q;
    out_sop   = busy_q & sop_q;
    out_eop   = busy_q & ~more;
    out_pid   = pid_q;
    out_meta  = meta_q;
    out_tmask = '0;
    out_data  = '0;
    for (int p = 0; p < NUM_PKTS; p++) begin
      if (pid_q == PID_W'(p)) begin
        out_tmask = tmask_q[p*NUM_LANES +: NUM_LANES];
        out_data  = data_q[p*PKT_DW +: PKT_DW];
      end
    end
    in_ready = ~busy_q | (out_ready & out_eop);
  end

endmodule

// File: tb/tb_vx_fpu_lane_splitter.sv
// Directed bench for vx_fpu_lane_splitter at NUM_THREADS=8, NUM_LANES=4.
// Build with +define+FPU_SPLIT_SKIP_EN to exercise partition skipping.
module tb_vx_fpu_lane_splitter;

  localparam int NT = 8;
  localparam int NL = 4;
  localparam int DW = 96;
  localparam int MW = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [NT-1:0] in_tmask;
  logic [NT*DW-1:0] in_data;
  logic [MW-1:0] in_meta;
  logic          out_valid;
  logic          out_ready;
  logic [NL-1:0] out_tmask;
  logic [NL*DW-1:0] out_data;
  logic [MW-1:0] out_meta;
  logic [0:0]    out_pid;
  logic          out_sop;
  logic          out_eop;

  int checks = 0;
  int failures = 0;

  vx_fpu_lane_splitter #(
    .NUM_THREADS(NT), .NUM_LANES(NL),
    .LANE_DATAW(DW), .META_W(MW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_tmask(in_tmask), .in_data(in_data),
    .in_meta(in_meta),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tmask(out_tmask), .out_data(out_data),
    .out_meta(out_meta), .out_pid(out_pid),
    .out_sop(out_sop), .out_eop(out_eop)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [511:0] act,
                       logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] lw(int seed, int t);
    return {32'(seed * 256 + t), 32'hDEAD0000 | 32'(t),
            ~32'(seed + t)};
  endfunction

  function automatic logic [NL*DW-1:0] pkt_data(int seed, int p);
    logic [NL*DW-1:0] d;
    for (int l = 0; l < NL; l++) d[l*DW +: DW] = lw(seed, p*NL + l);
    return d;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drive(logic [NT-1:0] m, logic [MW-1:0] meta,
                       int seed);
    in_valid = 1'b1;
    in_tmask = m;
    in_meta  = meta;
    for (int t = 0; t < NT; t++) in_data[t*DW +: DW] = lw(seed, t);
  endtask

  task automatic pkt(string tag, int pid, logic [NL-1:0] m,
                     logic sop, logic eop,
                     logic [MW-1:0] meta, int seed);
    check({tag, ".valid"}, 512'(out_valid), 512'(1'b1));
    check({tag, ".pid"},   512'(out_pid),   512'(pid));
    check({tag, ".tmask"}, 512'(out_tmask), 512'(m));
    check({tag, ".sop"},   512'(out_sop),   512'(sop));
    check({tag, ".eop"},   512'(out_eop),   512'(eop));
    check({tag, ".meta"},  512'(out_meta),  512'(meta));
    check({tag, ".data"},  512'(out_data),  512'(pkt_data(seed, pid)));
  endtask

  task automatic idle(string tag);
    samp();
    check({tag, ".idle_valid"}, 512'(out_valid), 512'(1'b0));
    check({tag, ".idle_ready"}, 512'(in_ready),  512'(1'b1));
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_tmask  = '0;
    in_data   = '0;
    in_meta   = '0;
    out_ready = 1'b1;
    #2;
    check("rst.valid", 512'(out_valid), 512'(1'b0));
    check("rst.ready", 512'(in_ready),  512'(1'b1));
    check("rst.sop",   512'(out_sop),   512'(1'b0));
    check("rst.eop",   512'(out_eop),   512'(1'b0));
    check("rst.pid",   512'(out_pid),   512'(1'b0));
    check("rst.tmask", 512'(out_tmask), 512'(4'h0));
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // Full mask: two packets.
    drive(8'hFF, 64'h1, 1);
    samp(); check("ff.in_ready", 512'(in_ready), 512'(1'b1));
    cyc(); in_valid = 1'b0;
    samp(); pkt("ff0", 0, 4'hF, 1, 0, 64'h1, 1);
    check("ff0.in_ready", 512'(in_ready), 512'(1'b0));
    cyc(); samp(); pkt("ff1", 1, 4'hF, 0, 1, 64'h1, 1);
    check("ff1.in_ready", 512'(in_ready), 512'(1'b1));
    cyc(); idle("ff");

    // Upper half only.
    drive(8'hF0, 64'h2, 2);
    cyc(); in_valid = 1'b0;
`ifdef FPU_SPLIT_SKIP_EN
    samp(); pkt("f0", 1, 4'hF, 1, 1, 64'h2, 2);
`else
    samp(); pkt("f0a", 0, 4'h0, 1, 0, 64'h2, 2);
    cyc(); samp(); pkt("f0b", 1, 4'hF, 0, 1, 64'h2, 2);
`endif
    cyc(); idle("f0");

    // Empty mask.
    drive(8'h00, 64'h3, 3);
    cyc(); in_valid = 1'b0;
`ifdef FPU_SPLIT_SKIP_EN
    samp(); pkt("z", 0, 4'h0, 1, 1, 64'h3, 3);
`else
    samp(); pkt("za", 0, 4'h0, 1, 0, 64'h3, 3);
    cyc(); samp(); pkt("zb", 1, 4'h0, 0, 1, 64'h3, 3);
`endif
    cyc(); idle("z");

    // Mixed mask, both partitions populated.
    drive(8'h5A, 64'h4, 4);
    cyc(); in_valid = 1'b0;
    samp(); pkt("5a0", 0, 4'hA, 1, 0, 64'h4, 4);
    cyc(); samp(); pkt("5a1", 1, 4'h5, 0, 1, 64'h4, 4);
    cyc(); idle("5a");

    // Backpressure: hold pid0 for N+1..N+3.
    drive(8'hFF, 64'h5, 5);
    cyc(); in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      samp(); pkt($sformatf("bp%0d", i), 0, 4'hF, 1, 0, 64'h5, 5);
      check($sformatf("bp%0d.in_ready", i), 512'(in_ready),
            512'(1'b0));
      cyc();
    end
    out_ready = 1'b1;
    samp(); pkt("bp4", 0, 4'hF, 1, 0, 64'h5, 5);
    check("bp4.in_ready", 512'(in_ready), 512'(1'b0));
    cyc(); samp(); pkt("bp5", 1, 4'hF, 0, 1, 64'h5, 5);
    check("bp5.in_ready", 512'(in_ready), 512'(1'b1));
    cyc(); idle("bp");

    // Back-to-back requests, no bubble.
    drive(8'hFF, 64'hA, 10);
    cyc();
    drive(8'hFF, 64'hB, 11);
    samp(); pkt("bbA0", 0, 4'hF, 1, 0, 64'hA, 10);
    check("bbA0.in_ready", 512'(in_ready), 512'(1'b0));
    cyc(); samp(); pkt("bbA1", 1, 4'hF, 0, 1, 64'hA, 10);
    check("bbA1.in_ready", 512'(in_ready), 512'(1'b1));
    cyc(); in_valid = 1'b0;
    samp(); pkt("bbB0", 0, 4'hF, 1, 0, 64'hB, 11);
    cyc(); samp(); pkt("bbB1", 1, 4'hF, 0, 1, 64'hB, 11);
    cyc(); idle("bb");

    // Reset during pid0 packet.
    drive(8'hFF, 64'h7, 7);
    cyc(); in_valid = 1'b0;
    samp(); pkt("rm0", 0, 4'hF, 1, 0, 64'h7, 7);
    #1 reset_n = 1'b0;
    #1;
    check("rm.valid", 512'(out_valid), 512'(1'b0));
    check("rm.eop",   512'(out_eop),   512'(1'b0));
    check("rm.ready", 512'(in_ready),  512'(1'b1));
    cyc(); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      samp();
      check($sformatf("rm.post%0d.valid", i), 512'(out_valid),
            512'(1'b0));
      check($sformatf("rm.post%0d.eop", i), 512'(out_eop),
            512'(1'b0));
      check($sformatf("rm.post%0d.ready", i), 512'(in_ready),
            512'(1'b1));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vx_fpu_lane_splitter.md
VX_FPU_LANE_SPLITTER -- requirements
Module: VX_fpu_lane_splitter

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 8: threads per incoming warp request.
REQ-002 SHALL have parameter NUM_LANES, default 4: FPU lanes per outgoing packet; NUM_THREADS SHALL be a multiple of it.
REQ-003 SHALL have parameter LANE_DATAW, default 96: per-thread operand bundle width (rs1/rs2/rs3).
REQ-004 SHALL have parameter META_W, default 64: opaque per-request metadata (uuid, wid, PC, rd, op_type, fmt, frm).
REQ-005 SHALL derive NUM_PKTS = NUM_THREADS/NUM_LANES and PID_W = max(1, clog2(NUM_PKTS)).
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 Ports, in order:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_tmask  in  NUM_THREADS  thread mask
- in_data  in  NUM_THREADS*LANE_DATAW  operands, thread 0 in LSBs
- in_meta  in  META_W  metadata
- out_valid  out  1  packet valid
- out_ready  in  1  packet consumed when out_valid & out_ready
- out_tmask  out  NUM_LANES  packet lane mask
- out_data  out  NUM_LANES*LANE_DATAW  packet operands
- out_meta  out  META_W  copy of captured in_meta
- out_pid  out  PID_W  partition index
- out_sop  out  1  first packet of request
- out_eop  out  1  last packet of request

Function
REQ-008 Partition p SHALL cover threads [p*NUM_LANES, (p+1)*NUM_LANES-1]; packet p carries exactly those tmask bits and operands.
REQ-009 in_ready SHALL equal ~busy | (out_valid & out_ready & out_eop); the combinational out_ready -> in_ready path is intended.
REQ-010 On input fire in cycle N, tmask/data/meta SHALL be captured and the first packet presented at out_valid in cycle N+1.
REQ-011 Packets SHALL be emitted in ascending pid, one per cycle while out_ready is high; a new packet follows each output fire in the next cycle.
REQ-012 out_sop SHALL be 1 only on the first emitted packet, out_eop only on the last; both 1 on single-packet requests.
REQ-013 While out_valid & ~out_ready, all out_* SHALL hold stable.
REQ-014 On output fire with out_eop coinciding with input fire, the new request's first packet SHALL appear next cycle (no bubble).
REQ-015 All-zero in_tmask SHALL produce exactly one packet: pid 0, tmask 0, sop=eop=1.
REQ-016 Next pid SHALL come from a priority encoder over captured partition-valid bits above the current pid; eop asserts when none remain.
REQ-017 out_meta SHALL be identical on every packet of a request.
REQ-018 When NUM_PKTS = 1, block SHALL act as a one-deep register slice with pid 0, sop=eop=1.

Reset
REQ-019 reset_n low SHALL immediately clear busy, out_valid, out_sop, out_eop, out_pid and out_tmask to 0; in_ready reads 1 during and after reset.
REQ-020 Reset mid-request SHALL discard remaining packets; no eop emitted; out_data/out_meta reset values are don't-care.

Configuration
REQ-021 Macro FPU_SPLIT_SKIP_EN: defined -> partitions with zero mask bits are skipped (REQ-016). Undefined -> all NUM_PKTS partitions emitted, including empty ones, sop on pid 0, eop on pid NUM_PKTS-1; REQ-015 is subsumed.

Verification (NUM_THREADS=8, NUM_LANES=4, out_ready=1 unless stated)
REQ-022 in_tmask=0xFF fire cycle N -> N+1: pid0 tmask 0xF sop1 eop0; N+2: pid1 tmask 0xF sop0 eop1; in_ready=1 at N+2.
REQ-023 in_tmask=0xF0 -> with SKIP_EN: one packet pid1 tmask 0xF sop=eop=1; without: pid0 tmask 0x0 sop1, then pid1 tmask 0xF eop1.
REQ-024 in_tmask=0x00 with SKIP_EN -> one packet pid0 tmask 0x0 sop=eop=1 at N+1.
REQ-025 in_tmask=0xFF, out_ready low for cycles N+1..N+3 -> pid0 packet held bit-stable; pid1 appears N+5; in_ready stays 0 until N+5.
REQ-026 Two requests back-to-back (meta 0xA, 0xB, tmask 0xFF) -> four consecutive packets, no idle cycle, meta A,A,B,B.
REQ-027 reset_n asserted during pid0 packet of 0xFF request -> out_valid 0 same cycle, no pid1/eop after release, in_ready 1.
